frame_buffer_arbiter: RTL and testbench
=======================================

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, SPRAM word address width ({y[8:0],x[9:0]}).
REQ-002 The block SHALL have parameter DATA_W, default 2, pixel width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of 2, >=2).
REQ-004 The block SHALL have parameter MAX_READ_RUN, default 8, consecutive read grants allowed while writes are pending.
REQ-005 The block SHALL have these ports:
- mainClk  in  1  sole clock.
- nreset  in  1  asynchronous active-low reset.
- rdReq  in  1  display read request.
- rdAddr  in  ADDR_W  read address.
- rdGnt  out  1  read accepted this cycle.
- rdData  out  DATA_W  read data.
- rdDataValid  out  1  rdData valid.
- wrValid  in  1  edge pixel offered.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- wrReady  out  1  write buffer can accept.
- memAddr  out  ADDR_W  SPRAM address.
- memWData  out  DATA_W  SPRAM write data.
- memWe  out  1  SPRAM write enable.
- memRData  in  DATA_W  SPRAM read data, registered, valid 1 cycle after address.
- statStall  out  16  read-stall count (see Configuration).

Function
REQ-006 A write SHALL be accepted into the FIFO on wrValid && wrReady; wrReady SHALL equal !full, computed from registered occupancy only (no same-cycle pop credit).
REQ-007 Exactly one SPRAM access SHALL occur per cycle at most: a read (memWe=0, memAddr=rdAddr), a write (memWe=1, memAddr/memWData = FIFO head, head popped), or none (memWe=0).
REQ-008 The FSM SHALL have states IDLE, READ_RUN, FORCE_WR.
REQ-009 IDLE: rdReq -> grant read, go READ_RUN, runCnt=1; else if FIFO non-empty -> issue write, stay IDLE; else idle.
REQ-010 READ_RUN: rdReq with FIFO empty or runCnt<MAX_READ_RUN -> grant read, runCnt+=1 (saturating); rdReq with FIFO non-empty and runCnt==MAX_READ_RUN -> go FORCE_WR, no grant; !rdReq -> go IDLE, runCnt=0, and issue a write if FIFO non-empty.
REQ-011 FORCE_WR SHALL last exactly one cycle: issue one write, rdGnt=0 regardless of rdReq, runCnt=0, return to IDLE.
REQ-012 runCnt SHALL reset to 0 whenever a cycle passes with rdGnt=0 in IDLE or READ_RUN.
REQ-013 rdGnt SHALL be combinational in the grant cycle; rdData=memRData and rdDataValid=1 exactly one cycle after each grant, rdDataValid=0 otherwise.
REQ-014 A push into an empty FIFO SHALL NOT bypass to SPRAM; its earliest write is the following cycle.
REQ-015 When full, a simultaneous pop SHALL NOT enable a push that cycle; wrReady rises the cycle after the pop.
REQ-016 FIFO SHALL preserve write order; pointers SHALL wrap modulo FIFO_DEPTH with a separate occupancy count distinguishing full from empty.
REQ-017 Read and write to the same address: the read SHALL return the SPRAM contents before any write still in the FIFO (no forwarding).

Reset
REQ-018 On nreset low, asynchronously: FSM=IDLE, runCnt=0, FIFO empty, rdGnt=0, rdDataValid=0, rdData=0, memWe=0, memAddr=0, memWData=0, statStall=0; wrReady=1 from the first cycle after release.
REQ-019 Reset mid-operation SHALL discard buffered writes and any read in flight; no memWe pulse during reset.

Configuration
REQ-020 With ARB_STATS_EN defined, statStall SHALL count cycles with rdReq=1 and rdGnt=0, saturating at 16'hFFFF, cleared only by reset.
REQ-021 Without ARB_STATS_EN, statStall SHALL be constant 0 and the counter SHALL not be synthesized.

Verification
REQ-022 Reset, then wrValid with wrAddr=0x00005, wrData=2'b11, rdReq=0 -> memWe=1, memAddr=0x00005, memWData=2'b11 on the next cycle.
REQ-023 rdReq held high for 20 cycles, 1 write buffered, MAX_READ_RUN=8 -> rdGnt high cycles 1-8, cycle 9 FORCE_WR with memWe=1 and rdGnt=0, reads resume cycle 10.
REQ-024 rdReq held, wrValid held, FIFO_DEPTH=4 -> wrReady drops after 4 accepts; 1 write drains per 9 cycles; no data loss or reordering.
REQ-025 Grant read at rdAddr=0x00400 with SPRAM holding 2'b10 -> rdDataValid=1, rdData=2'b10 exactly one cycle later.
REQ-026 Assert nreset with 3 writes buffered -> memWe never pulses, wrReady=1 after release, FIFO empty; with ARB_STATS_EN, 5 stalled cycles -> statStall=5.

Source files
------------

// File: rtl/frame_buffer_arbiter_if.sv
// Frame buffer arbiter bus bundle: display read port, edge-pixel write port,
// single-ported SPRAM port and the stall statistic.
// slave  : arbiter side
// master : client / memory side
interface frame_buffer_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 2
);
    // display read port
    logic              rdReq;
    logic [ADDR_W-1:0] rdAddr;
    logic              rdGnt;
    logic [DATA_W-1:0] rdData;
    logic              rdDataValid;
    // edge-pixel write port
    logic              wrValid;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              wrReady;
    // SPRAM port
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memWe;
    logic [DATA_W-1:0] memRData;
    // statistics
    logic [15:0]       statStall;

    modport slave (
        input  rdReq, rdAddr, wrValid, wrAddr, wrData, memRData,
        output rdGnt, rdData, rdDataValid, wrReady, memAddr, memWData, memWe, statStall
    );

    modport master (
        output rdReq, rdAddr, wrValid, wrAddr, wrData, memRData,
        input  rdGnt, rdData, rdDataValid, wrReady, memAddr, memWData, memWe, statStall
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one SPRAM port between display reads (priority)
// and buffered edge-pixel writes. Reads may run for at most MAX_READ_RUN grants
// while writes wait, after which one write is forced in.
// Optional feature macro: ARB_STATS_EN (read-stall cycle counter on statStall).
module frame_buffer_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_READ_RUN = 8
) (
    input  logic mainClk,
    input  logic nreset,
    frame_buffer_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RUN_W = $clog2(MAX_READ_RUN + 1);

    typedef enum logic [1:0] {IDLE, READ_RUN, FORCE_WR} state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic              rd_vld_q;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic full, empty, push, pop, gnt;

    // Occupancy comes from registers only: a pop never frees a slot for the
    // same cycle, and a fresh push is never visible to the SPRAM side yet.
    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = bus.wrValid && !full;

    // Arbitration: choose this cycle's SPRAM access and the next state.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        gnt     = 1'b0;
        pop     = 1'b0;
        if (nreset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rdReq) begin
                        gnt     = 1'b1;
                        run_d   = RUN_W'(1);
                        state_d = READ_RUN;
                    end else begin
                        run_d = '0;
                        pop   = !empty;
                    end
                end
                READ_RUN: begin
                    if (!bus.rdReq) begin
                        state_d = IDLE;
                        run_d   = '0;
                        pop     = !empty;
                    end else if (empty || run_q < RUN_W'(MAX_READ_RUN)) begin
                        gnt   = 1'b1;
                        run_d = (run_q < RUN_W'(MAX_READ_RUN)) ? run_q + RUN_W'(1) : run_q;
                    end else begin
                        state_d = FORCE_WR;
                        run_d   = '0;
                    end
                end
                FORCE_WR: begin
                    pop     = !empty;
                    run_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        // The grant that uses up the read budget hands the very next slot to a
        // waiting write, so a saturated read stream yields one write per
        // MAX_READ_RUN+1 cycles without an extra idle cycle.
        if (gnt && run_d == RUN_W'(MAX_READ_RUN) && cnt_d != '0)
            state_d = FORCE_WR;
    end

    // FSM, run counter, FIFO pointers/occupancy and read-data-valid pipeline.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            run_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= gnt;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Write-buffer storage; contents are meaningless once the pointers reset.
    always_ff @(posedge mainClk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.wrAddr;
            fifo_data_q[wr_ptr_q] <= bus.wrData;
        end
    end

    assign bus.rdGnt       = gnt;
    assign bus.wrReady     = !full;
    assign bus.memWe       = pop;
    assign bus.memAddr     = gnt ? bus.rdAddr : (pop ? fifo_addr_q[rd_ptr_q] : '0);
    assign bus.memWData    = pop ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.rdDataValid = rd_vld_q;
    assign bus.rdData      = rd_vld_q ? bus.memRData : '0;

`ifdef ARB_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where the display asked and was refused; sticks at max.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset)
            stall_q <= '0;
        else if (bus.rdReq && !gnt && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign bus.statStall = stall_q;
`else
    assign bus.statStall = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a registered SPRAM model.
module tb_frame_buffer_arbiter;

    logic mainClk;
    logic nreset;
    int   ntests = 0;
    int   nfail  = 0;

    frame_buffer_arbiter_if #(.ADDR_W(19), .DATA_W(2)) bus ();

    frame_buffer_arbiter dut (
        .mainClk (mainClk),
        .nreset  (nreset),
        .bus     (bus)
    );

    initial mainClk = 1'b0;
    always #5 mainClk = ~mainClk;

    // SPRAM model: read data registered one cycle after the address,
    // read-before-write; every write is logged in order.
    logic [1:0]  mem [logic [18:0]];
    logic [18:0] wlog_a [$];
    logic [1:0]  wlog_d [$];

    always @(posedge mainClk) begin
        logic [1:0] rd;
        rd = mem.exists(bus.memAddr) ? mem[bus.memAddr] : 2'b00;
        bus.memRData <= rd;
        if (bus.memWe) begin
            mem[bus.memAddr] = bus.memWData;
            wlog_a.push_back(bus.memAddr);
            wlog_d.push_back(bus.memWData);
        end
    end

    task automatic tick();
        @(posedge mainClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int acc;
        int lstart;
        logic exp_rdy;
        logic [31:0] exp_stall;

        nreset       = 1'b0;
        bus.rdReq    = 1'b1;
        bus.rdAddr   = '0;
        bus.wrValid  = 1'b0;
        bus.wrAddr   = '0;
        bus.wrData   = '0;
        bus.memRData = '0;

        // Reset state (read request held high must not be granted)
        @(negedge mainClk);
        chk("rst_rdGnt",       32'(bus.rdGnt),       32'd0);
        chk("rst_memWe",       32'(bus.memWe),       32'd0);
        chk("rst_memAddr",     32'(bus.memAddr),     32'd0);
        chk("rst_memWData",    32'(bus.memWData),    32'd0);
        chk("rst_rdDataValid", 32'(bus.rdDataValid), 32'd0);
        chk("rst_rdData",      32'(bus.rdData),      32'd0);
        chk("rst_statStall",   32'(bus.statStall),   32'd0);
        bus.rdReq = 1'b0;
        tick();
        nreset = 1'b1;
        @(negedge mainClk);
        chk("rel_wrReady", 32'(bus.wrReady), 32'd1);

        // Single write: no bypass, appears on SPRAM the following cycle
        tick();
        bus.wrValid = 1'b1; bus.wrAddr = 19'h00005; bus.wrData = 2'b11;
        @(negedge mainClk);
        chk("w1_wrReady",   32'(bus.wrReady), 32'd1);
        chk("w1_no_bypass", 32'(bus.memWe),   32'd0);
        tick();
        bus.wrValid = 1'b0;
        @(negedge mainClk);
        chk("w1_memWe",    32'(bus.memWe),    32'd1);
        chk("w1_memAddr",  32'(bus.memAddr),  32'h5);
        chk("w1_memWData", 32'(bus.memWData), 32'd3);
        tick();
        @(negedge mainClk);
        chk("w1_done", 32'(bus.memWe), 32'd0);

        // Read latency: data valid exactly one cycle after the grant
        mem[19'h00400] = 2'b10;
        tick();
        bus.rdReq = 1'b1; bus.rdAddr = 19'h00400;
        @(negedge mainClk);
        chk("r1_rdGnt",   32'(bus.rdGnt),   32'd1);
        chk("r1_memAddr", 32'(bus.memAddr), 32'h400);
        chk("r1_memWe",   32'(bus.memWe),   32'd0);
        tick();
        bus.rdReq = 1'b0;
        @(negedge mainClk);
        chk("r1_valid", 32'(bus.rdDataValid), 32'd1);
        chk("r1_data",  32'(bus.rdData),      32'd2);
        chk("r1_nognt", 32'(bus.rdGnt),       32'd0);
        tick();
        @(negedge mainClk);
        chk("r1_valid_off", 32'(bus.rdDataValid), 32'd0);

        // Same address: read sees SPRAM contents, not the buffered write
        tick();
        bus.rdReq = 1'b1; bus.rdAddr = 19'h00005;
        bus.wrValid = 1'b1; bus.wrAddr = 19'h00005; bus.wrData = 2'b01;
        @(negedge mainClk);
        chk("sa_rdGnt", 32'(bus.rdGnt), 32'd1);
        chk("sa_memWe", 32'(bus.memWe), 32'd0);
        tick();
        bus.rdReq = 1'b0; bus.wrValid = 1'b0;
        @(negedge mainClk);
        chk("sa_rdData",   32'(bus.rdData),   32'd3);
        chk("sa_memWe",    32'(bus.memWe),    32'd1);
        chk("sa_memAddr",  32'(bus.memAddr),  32'h5);
        chk("sa_memWData", 32'(bus.memWData), 32'd1);
        tick();
        bus.rdReq = 1'b1; bus.rdAddr = 19'h00005;
        tick();
        bus.rdReq = 1'b0;
        @(negedge mainClk);
        chk("sa_reread", 32'(bus.rdData), 32'd1);

        // Read run of 20 with one buffered write: forced write at cycle 9
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.rdReq   = 1'b1;
            bus.rdAddr  = 19'h00010;
            bus.wrValid = (c == 1);
            bus.wrAddr  = 19'h00020;
            bus.wrData  = 2'b10;
            @(negedge mainClk);
            chk($sformatf("run_rdGnt_c%0d", c), 32'(bus.rdGnt), 32'(c != 9));
            chk($sformatf("run_memWe_c%0d", c), 32'(bus.memWe), 32'(c == 9));
            if (c == 9) begin
                chk("run_fw_addr", 32'(bus.memAddr),  32'h20);
                chk("run_fw_data", 32'(bus.memWData), 32'd2);
            end
        end
        tick();
        bus.rdReq = 1'b0; bus.wrValid = 1'b0;
        @(negedge mainClk);
        chk("run_end_memWe", 32'(bus.memWe), 32'd0);

        // Reset with three writes buffered behind an active read run
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.rdReq = 1'b1; bus.rdAddr = 19'h00011;
            bus.wrValid = 1'b1; bus.wrAddr = 19'(32'h30 + c); bus.wrData = 2'(c);
            @(negedge mainClk);
            chk($sformatf("pre_rst_gnt_%0d", c), 32'(bus.rdGnt), 32'd1);
            chk($sformatf("pre_rst_we_%0d", c),  32'(bus.memWe), 32'd0);
        end
        tick();
        nreset = 1'b0; bus.wrValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge mainClk);
            chk($sformatf("inrst_memWe_%0d", i), 32'(bus.memWe),       32'd0);
            chk($sformatf("inrst_rdGnt_%0d", i), 32'(bus.rdGnt),       32'd0);
            chk($sformatf("inrst_rdv_%0d", i),   32'(bus.rdDataValid), 32'd0);
            tick();
        end
        nreset = 1'b1; bus.rdReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mainClk);
            chk($sformatf("postrst_memWe_%0d", i),   32'(bus.memWe),   32'd0);
            chk($sformatf("postrst_wrReady_%0d", i), 32'(bus.wrReady), 32'd1);
            tick();
        end

        // Saturated reads and writes: 4 accepts, then one drain per 9 cycles
        lstart = wlog_a.size();
        acc = 0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            bus.rdReq   = 1'b1;
            bus.rdAddr  = 19'(c);
            bus.wrValid = 1'b1;
            bus.wrAddr  = 19'(32'h100 + acc);
            bus.wrData  = 2'(acc & 3);
            @(negedge mainClk);
            exp_rdy = (c <= 4) || (c > 9 && (c % 9) == 1);
            chk($sformatf("sat_wrReady_c%0d", c), 32'(bus.wrReady), 32'(exp_rdy));
            chk($sformatf("sat_rdGnt_c%0d", c),   32'(bus.rdGnt),   32'((c % 9) != 0));
            chk($sformatf("sat_memWe_c%0d", c),   32'(bus.memWe),   32'((c % 9) == 0));
            if (exp_rdy) acc++;
        end
        tick();
        bus.rdReq = 1'b0; bus.wrValid = 1'b0;
        @(negedge mainClk);
`ifdef ARB_STATS_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        chk("stat_stall", 32'(bus.statStall), exp_stall);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_accepts", 32'(acc), 32'd8);
        chk("sat_nwrites", 32'(wlog_a.size() - lstart), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (lstart + k < wlog_a.size()) begin
                chk($sformatf("order_addr_%0d", k), 32'(wlog_a[lstart + k]), 32'h100 + 32'(k));
                chk($sformatf("order_data_%0d", k), 32'(wlog_d[lstart + k]), 32'(k & 3));
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
